// File: rtl/accum_ram_pkg.sv
// Purpose : shared types and constants for the accumulate-into-RAM controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, latched command encoding, default widths, saturation limits.
package accum_ram_pkg;

    localparam int AWIDTH_DEF    = 11;
    localparam int NUM_WORDS_DEF = 2048;
    localparam int DWIDTH_DEF    = 40;
    localparam int IWIDTH_DEF    = 32;

    // Signed accumulator limits, two's complement over DWIDTH_DEF bits.
    localparam logic [DWIDTH_DEF-1:0] ACC_MAX = {1'b0, {(DWIDTH_DEF-1){1'b1}}};
    localparam logic [DWIDTH_DEF-1:0] ACC_MIN = {1'b1, {(DWIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_CLEAR = 2'd1,
        CMD_DRAIN = 2'd2
    } cmd_e;

endpackage

// File: rtl/accum_ram_ctrl_if.sv
// Purpose : partial-sum input stream (valid/ready) into the accumulation controller.
// Latency : n/a (wires only).
// Backpressure: producer holds in_valid/in_addr/in_data until it sees in_ready high.
// Ports   : in_valid, in_addr, in_data from producer; in_ready from controller.
interface accum_ram_ctrl_if
    import accum_ram_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int IWIDTH = IWIDTH_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [AWIDTH-1:0] in_addr;
    logic [IWIDTH-1:0] in_data;

    modport master (output in_valid, output in_addr, output in_data, input in_ready);
    modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/accum_ram_add.sv
// Purpose : sign-extend a partial sum and add it to an accumulator word.
// Latency : combinational.
// Backpressure: n/a.
// Ports   : old_i accumulator, inc_i signed partial sum, sum_o result, ovf_o saturation hit.
// Build   : ACCUM_SAT_EN defined -> saturate to signed limits; undefined -> wrap, ovf_o = 0.
module accum_ram_add
    import accum_ram_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int IWIDTH = IWIDTH_DEF
) (
    input  logic [DWIDTH-1:0] old_i,
    input  logic [IWIDTH-1:0] inc_i,
    output logic [DWIDTH-1:0] sum_o,
    output logic              ovf_o
);
    logic [DWIDTH-1:0] inc_ext;
    logic [DWIDTH-1:0] raw;

    assign inc_ext = {{(DWIDTH-IWIDTH){inc_i[IWIDTH-1]}}, inc_i};
    assign raw     = old_i + inc_ext;

`ifdef ACCUM_SAT_EN
    logic wrapped;
    // Same-sign operands giving an opposite-sign result is a signed overflow;
    // the direction follows the operands' common sign.
    assign wrapped = (old_i[DWIDTH-1] == inc_ext[DWIDTH-1]) && (raw[DWIDTH-1] != old_i[DWIDTH-1]);
    assign sum_o   = wrapped ? (old_i[DWIDTH-1] ? ACC_MIN : ACC_MAX) : raw;
    assign ovf_o   = wrapped;
`else
    assign sum_o = raw;
    assign ovf_o = 1'b0;
`endif
endmodule

// File: rtl/accum_ram_ctrl.sv
// Purpose : read-modify-write accumulation into a 2-port RAM, plus full clear and sequential drain.
// Latency : transfer to RAM updated in 2 edges; drained word appears 1 cycle after its read.
// Backpressure: in_ready low outside IDLE and on a command cycle; drain output has none.
// Ports   : clk/reset; in_if (slave) stream; clear_start/drain_start; busy; out_valid/addr/data;
//           overflow (sticky, only with ACCUM_SAT_EN); ram_* drive port A (read/clear) and B (write).
module accum_ram_ctrl
    import accum_ram_pkg::*;
#(
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int IWIDTH    = IWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    accum_ram_ctrl_if.slave   in_if,
    input  logic              clear_start,
    input  logic              drain_start,
    output logic              busy,
    output logic              out_valid,
    output logic [AWIDTH-1:0] out_addr,
    output logic [DWIDTH-1:0] out_data,
    output logic              overflow,
    output logic [AWIDTH-1:0] ram_addr_a,
    output logic [AWIDTH-1:0] ram_addr_b,
    output logic              ram_wren_a,
    output logic              ram_wren_b,
    output logic [DWIDTH-1:0] ram_data_a,
    output logic [DWIDTH-1:0] ram_data_b,
    input  logic [DWIDTH-1:0] ram_out_a
);
    localparam logic [AWIDTH-1:0] LAST_PAIR = AWIDTH'(NUM_WORDS - 2);
    localparam logic [AWIDTH:0]   CNT_ONE   = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0]   CNT_TWO   = {{(AWIDTH-1){1'b0}}, 2'b10};

    state_e state_q, state_d;
    cmd_e   cmd_q, cmd_d;
    // One extra bit: in DRAIN the top bit marks "all reads issued".
    logic [AWIDTH:0] cnt_q, cnt_d;

    logic              s1_vld_q, wb_vld_q, rd_vld_q, overflow_q;
    logic [AWIDTH-1:0] s1_addr_q, wb_addr_q, rd_addr_q;
    logic [IWIDTH-1:0] s1_data_q;
    logic [DWIDTH-1:0] wb_data_q;

    logic              in_rdy, xfer, drain_rd, fwd_hit, sat_hit;
    logic [DWIDTH-1:0] old_val, sum;

    assign in_rdy         = (state_q == ST_IDLE) && !clear_start && !drain_start;
    assign in_if.in_ready = in_rdy;
    assign xfer           = in_if.in_valid && in_rdy;
    assign drain_rd       = (state_q == ST_DRAIN) && !cnt_q[AWIDTH];

    // The RAM read for the word in S1 was launched while the previous write-back
    // was still landing, so that write-back must be bypassed in.
    assign fwd_hit = wb_vld_q && (wb_addr_q == s1_addr_q);
    assign old_val = fwd_hit ? wb_data_q : ram_out_a;

    accum_ram_add #(.DWIDTH(DWIDTH), .IWIDTH(IWIDTH)) u_add (
        .old_i (old_val),
        .inc_i (s1_data_q),
        .sum_o (sum),
        .ovf_o (sat_hit)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    cmd_d   = CMD_CLEAR;
                    state_d = ST_FLUSH;
                end else if (drain_start) begin
                    cmd_d   = CMD_DRAIN;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!s1_vld_q && !wb_vld_q) begin
                    state_d = (cmd_q == CMD_CLEAR) ? ST_CLEAR : ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + CNT_TWO;
                if (cnt_q[AWIDTH-1:0] == LAST_PAIR) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NONE;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (!cnt_q[AWIDTH]) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    // Last read's data is on out_* this cycle.
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: RAM port control.
    always_comb begin
        ram_addr_a = '0;
        ram_wren_a = 1'b0;
        ram_data_a = '0;
        ram_addr_b = '0;
        ram_wren_b = 1'b0;
        ram_data_b = '0;
        if (s1_vld_q) begin
            ram_addr_b = s1_addr_q;
            ram_wren_b = 1'b1;
            ram_data_b = sum;
        end
        case (state_q)
            ST_IDLE: begin
                if (xfer) ram_addr_a = in_if.in_addr;
            end
            ST_CLEAR: begin
                // cnt is always even here, so k+1 is just the low bit set.
                ram_addr_a = cnt_q[AWIDTH-1:0];
                ram_wren_a = 1'b1;
                ram_addr_b = {cnt_q[AWIDTH-1:1], 1'b1};
                ram_wren_b = 1'b1;
            end
            ST_DRAIN: begin
                if (drain_rd) ram_addr_a = cnt_q[AWIDTH-1:0];
            end
            default: ;
        endcase
    end

    // Pipeline, forwarding, drain output and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            wb_vld_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_vld_q <= xfer;
            if (xfer) begin
                s1_addr_q <= in_if.in_addr;
                s1_data_q <= in_if.in_data;
            end
            wb_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                wb_addr_q <= s1_addr_q;
                wb_data_q <= sum;
            end
            rd_vld_q <= drain_rd;
            if (drain_rd) rd_addr_q <= cnt_q[AWIDTH-1:0];
            if (state_q == ST_FLUSH && state_d == ST_CLEAR) overflow_q <= 1'b0;
            else if (s1_vld_q && sat_hit)                 overflow_q <= 1'b1;
        end
    end

    assign busy      = (state_q != ST_IDLE) || s1_vld_q || wb_vld_q || rd_vld_q;
    assign out_valid = rd_vld_q;
    assign out_addr  = rd_addr_q;
    assign out_data  = rd_vld_q ? ram_out_a : '0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_accum_ram_ctrl.sv
module tb_accum_ram_ctrl;
    localparam int AW = 11;
    localparam int NW = 2048;
    localparam int DW = 40;
    localparam int IW = 32;
    localparam longint MAXV = 64'sd549755813887;
    localparam longint MINV = -64'sd549755813888;
    localparam longint MODV = 64'sd1099511627776;

    logic clk = 1'b0;
    logic reset;
    logic clear_start, drain_start;
    logic busy, out_valid, overflow;
    logic [AW-1:0] out_addr, ram_addr_a, ram_addr_b;
    logic [DW-1:0] out_data, ram_data_a, ram_data_b, ram_q;
    logic ram_wren_a, ram_wren_b;

    always #5 clk = ~clk;

    accum_ram_ctrl_if #(.AWIDTH(AW), .IWIDTH(IW)) in_if ();

    accum_ram_ctrl dut (
        .clk(clk), .reset(reset), .in_if(in_if),
        .clear_start(clear_start), .drain_start(drain_start),
        .busy(busy), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .overflow(overflow),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_out_a(ram_q)
    );

    // External RAM: registered read on port A, no read output on a writing port.
    logic [DW-1:0] ram [NW];
    always @(posedge clk) begin
        if (ram_wren_a) ram[ram_addr_a] <= ram_data_a;
        else            ram_q <= ram[ram_addr_a];
        if (ram_wren_b) ram[ram_addr_b] <= ram_data_b;
    end

    int errors = 0;
    int checks = 0;

    // Reference: true signed value of every word.
    longint model [NW];
    bit     exp_ovf;

    int            got_cnt;
    logic [AW-1:0] got_addr [NW];
    logic [DW-1:0] got_data [NW];
    bit            rdy_seen, tmo;
    int            busy_cyc, wr_cyc, pair_bad, out_cnt;

    task automatic model_add(input int a, input int d);
        longint s;
        s = model[a] + longint'(d);
`ifdef ACCUM_SAT_EN
        if (s > MAXV) begin s = MAXV; exp_ovf = 1'b1; end
        else if (s < MINV) begin s = MINV; exp_ovf = 1'b1; end
`else
        if (s > MAXV) s = s - MODV;
        else if (s < MINV) s = s + MODV;
`endif
        model[a] = s;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input int a, input int d);
        int n = 0;
        in_if.in_valid = 1'b1;
        in_if.in_addr  = AW'(a);
        in_if.in_data  = d;
        #1;
        while (in_if.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_accept addr=%0d in_ready=%b required 1 within 100 cycles", a, in_if.in_ready);
        end else begin
            model_add(a, d);
        end
        @(posedge clk); #1;
        in_if.in_valid = 1'b0;
    endtask

    task automatic run_drain();
        int cyc = 0;
        got_cnt = 0; rdy_seen = 0; tmo = 0;
        drain_start = 1'b1;
        #1;
        if (in_if.in_ready !== 1'b0) rdy_seen = 1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        while (busy === 1'b1 && cyc < 3000) begin
            if (in_if.in_ready !== 1'b0) rdy_seen = 1;
            if (out_valid === 1'b1) begin
                if (got_cnt < NW) begin
                    got_addr[got_cnt] = out_addr;
                    got_data[got_cnt] = out_data;
                end
                got_cnt++;
            end
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 3000) tmo = 1;
    endtask

    task automatic run_clear(input bit also_drain);
        int cyc = 0;
        int k = 0;
        busy_cyc = 0; wr_cyc = 0; pair_bad = 0; out_cnt = 0; tmo = 0;
        clear_start = 1'b1;
        drain_start = also_drain;
        @(posedge clk); #1;
        clear_start = 1'b0;
        drain_start = 1'b0;
        while (busy === 1'b1 && cyc < 3000) begin
            busy_cyc++;
            if (out_valid === 1'b1) out_cnt++;
            if (ram_wren_a === 1'b1 && ram_wren_b === 1'b1) begin
                if (ram_addr_a !== AW'(k) || ram_addr_b !== AW'(k + 1) ||
                    ram_data_a !== '0 || ram_data_b !== '0) pair_bad++;
                k += 2;
                wr_cyc++;
            end
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 3000) tmo = 1;
        for (int i = 0; i < NW; i++) model[i] = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        #1;
        checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_if.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr got %0d required 0", out_addr); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b required 0", overflow); end
        checks++; if (ram_wren_a !== 1'b0 || ram_wren_b !== 1'b0) begin errors++; $display("FAIL reset_wren got %b%b required 00", ram_wren_a, ram_wren_b); end
        checks++; if (ram_addr_a !== '0 || ram_addr_b !== '0 || ram_data_b !== '0) begin errors++; $display("FAIL reset_ram_bus got a=%0d b=%0d db=%h required 0", ram_addr_a, ram_addr_b, ram_data_b); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_clear(1'b0);
        checks++; if (tmo || wr_cyc != 1024) begin errors++; $display("FAIL clear_writes got %0d required 1024 (timeout=%0d)", wr_cyc, tmo); end
        checks++; if (pair_bad != 0) begin errors++; $display("FAIL clear_pairs got %0d bad cycles required 0", pair_bad); end
        send(5, 10);
        send(5, 20);
        send(5, -7);
        run_drain();
        checks++; if (tmo || got_cnt != NW) begin errors++; $display("FAIL basic_count got %0d required %0d (timeout=%0d)", got_cnt, NW, tmo); end
        checks++; if ($signed(got_data[5]) !== 64'sd23) begin errors++; $display("FAIL basic_addr5 got %0d required 23", $signed(got_data[5])); end
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || $signed(got_data[i]) !== model[i]) begin
                errors++;
                $display("FAIL basic_word idx=%0d got addr=%0d data=%0d required addr=%0d data=%0d", i, got_addr[i], $signed(got_data[i]), i, model[i]);
            end
        end
    endtask

    task automatic test_alternate();
        run_clear(1'b0);
        for (int i = 0; i < 100; i++) send((i % 2 == 0) ? 1 : 2, 1);
        run_drain();
        checks++; if (tmo || got_cnt != NW) begin errors++; $display("FAIL alt_count got %0d required %0d", got_cnt, NW); end
        checks++; if ($signed(got_data[1]) !== 64'sd50) begin errors++; $display("FAIL alt_addr1 got %0d required 50", $signed(got_data[1])); end
        checks++; if ($signed(got_data[2]) !== 64'sd50) begin errors++; $display("FAIL alt_addr2 got %0d required 50", $signed(got_data[2])); end
        checks++; if (got_data[0] !== '0 || got_data[3] !== '0) begin errors++; $display("FAIL alt_neighbours got %h/%h required 0/0", got_data[0], got_data[3]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NW - 1)) : int'($urandom_range(0, 7));
            send(a, int'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        run_drain();
        checks++; if (tmo || got_cnt != NW) begin errors++; $display("FAIL rand_count got %0d required %0d", got_cnt, NW); end
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || $signed(got_data[i]) !== model[i]) begin
                errors++;
                $display("FAIL rand_word idx=%0d got addr=%0d data=%0d required addr=%0d data=%0d", i, got_addr[i], $signed(got_data[i]), i, model[i]);
            end
        end
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_overflow got %b required %b", overflow, exp_ovf); end
    endtask

    task automatic test_both_cmds();
        run_clear(1'b1);
        checks++; if (tmo || wr_cyc != 1024) begin errors++; $display("FAIL both_clear_writes got %0d required 1024", wr_cyc); end
        checks++; if (out_cnt != 0) begin errors++; $display("FAIL both_out_valid got %0d pulses required 0", out_cnt); end
        checks++; if (busy_cyc < 1024 || busy_cyc > 1027) begin errors++; $display("FAIL both_busy_cycles got %0d required 1024..1027", busy_cyc); end
        checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL both_idle_ready got %b required 1", in_if.in_ready); end
    endtask

    task automatic test_flush();
        int d;
        d = int'($urandom);
        in_if.in_valid = 1'b1;
        in_if.in_addr  = AW'(777);
        in_if.in_data  = d;
        #1;
        checks++;
        if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL flush_accept got in_ready=%b required 1", in_if.in_ready); end
        else model_add(777, d);
        @(posedge clk); #1;
        run_drain();
        in_if.in_valid = 1'b0;
        checks++; if (rdy_seen) begin errors++; $display("FAIL flush_in_ready got high during drain required 0"); end
        checks++; if (tmo || got_cnt != NW) begin errors++; $display("FAIL flush_count got %0d required %0d", got_cnt, NW); end
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || $signed(got_data[i]) !== model[i]) begin
                errors++;
                $display("FAIL flush_word idx=%0d got addr=%0d data=%0d required addr=%0d data=%0d", i, got_addr[i], $signed(got_data[i]), i, model[i]);
            end
        end
    endtask

    task automatic test_saturation();
        longint rem, c, exp_val;
        bit exp_flag;
        run_clear(1'b0);
        rem = MAXV + 1 - 100;
        while (rem > 0) begin
            c = (rem > 64'sd2147483647) ? 64'sd2147483647 : rem;
            send(0, int'(c));
            rem = rem - c;
        end
        send(0, 1000);
`ifdef ACCUM_SAT_EN
        exp_val  = MAXV;
        exp_flag = 1'b1;
`else
        exp_val  = MINV + 900;
        exp_flag = 1'b0;
`endif
        run_drain();
        checks++; if (tmo || got_cnt != NW) begin errors++; $display("FAIL sat_count got %0d required %0d", got_cnt, NW); end
        checks++; if ($signed(got_data[0]) !== exp_val) begin errors++; $display("FAIL sat_value got %0d required %0d", $signed(got_data[0]), exp_val); end
        checks++; if (overflow !== exp_flag) begin errors++; $display("FAIL sat_overflow got %b required %b", overflow, exp_flag); end
        checks++; if (got_data[1] !== '0) begin errors++; $display("FAIL sat_neighbour got %h required 0", got_data[1]); end
        run_clear(1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_overflow_cleared got %b required 0", overflow); end
    endtask

    task automatic test_reset_mid_drain();
        drain_start = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL middrain_active got valid=%b busy=%b required 1/1", out_valid, busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL middrain_out_valid got %b required 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL middrain_busy got %b required 0", busy); end
        checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL middrain_in_ready got %b required 1", in_if.in_ready); end
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_addr  = '0;
        in_if.in_data  = '0;
        clear_start    = 1'b0;
        drain_start    = 1'b0;
        exp_ovf        = 1'b0;
        for (int i = 0; i < NW; i++) model[i] = 0;
        test_reset();
        test_basic();
        test_alternate();
        test_random();
        test_both_cmds();
        test_flush();
        test_saturation();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
